// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit with architectural HI/LO
//            registers. Radix-2 shift-add multiplier and restoring divider
//            share one 2*WIDTH-bit working register; each operation takes
//            WIDTH+2 cycles from the start strobe to the done pulse.
// Ports    : clock_i   - rising-edge clock
//            reset_i   - synchronous active-high reset
//            start_i   - request strobe, sampled only while busy_o=0
//            op_i      - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//            src_a_i   - multiplicand / dividend / MTHI-MTLO data
//            src_b_i   - multiplier / divisor
//            busy_o    - mul/div in flight (registered)
//            done_o    - one-cycle pulse when new results appear on hi/lo
//            hi_o/lo_o - HI and LO registers
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    // Multiply: running product. Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0]     acc_q;
    // Multiply: multiplicand magnitude. Divide: divisor magnitude.
    logic [WIDTH-1:0]       opnd_q;
    logic                   is_div_q;
    logic                   neg_q;       // negate product / quotient
    logic                   rem_neg_q;   // remainder follows dividend sign
    logic                   div_zero_q;
    logic [WIDTH-1:0]       a_orig_q;
    logic                   busy_q;
    logic                   done_q;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;

    logic                   sgn_d;
    logic [WIDTH-1:0]       mag_a_d;
    logic [WIDTH-1:0]       mag_b_d;
    logic [WIDTH:0]         mul_sum_d;
    logic [WIDTH:0]         div_shift_d;
    logic [WIDTH:0]         div_diff_d;
    logic [2*WIDTH-1:0]     acc_step_d;
    logic [2*WIDTH-1:0]     prod_fin_d;
    logic [WIDTH-1:0]       hi_fin_d;
    logic [WIDTH-1:0]       lo_fin_d;

    // Operand conditioning at the start strobe.
    always_comb begin
        sgn_d   = (op_i == OP_MULT) || (op_i == OP_DIV);
        mag_a_d = (sgn_d && src_a_i[WIDTH-1]) ? (~src_a_i) + WIDTH'(1) : src_a_i;
        mag_b_d = (sgn_d && src_b_i[WIDTH-1]) ? (~src_b_i) + WIDTH'(1) : src_b_i;
    end

    // One iteration of either algorithm, plus the FINISH-cycle sign fix-up.
    always_comb begin
        mul_sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        div_shift_d = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff_d  = div_shift_d - {1'b0, opnd_q};

        if (!is_div_q) begin
            // Add on multiplier LSB, then shift the whole product right.
            acc_step_d = acc_q[0] ? {mul_sum_d, acc_q[WIDTH-1:1]}
                                  : {1'b0, acc_q[2*WIDTH-1:1]};
        end else if (div_diff_d[WIDTH]) begin
            // Trial subtraction went negative: restore, quotient bit 0.
            acc_step_d = {div_shift_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_step_d = {div_diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end

        prod_fin_d = neg_q ? (~acc_q) + (2*WIDTH)'(1) : acc_q;

        if (!is_div_q) begin
            hi_fin_d = prod_fin_d[2*WIDTH-1:WIDTH];
            lo_fin_d = prod_fin_d[WIDTH-1:0];
        end else if (div_zero_q) begin
            hi_fin_d = a_orig_q;
            lo_fin_d = '1;
        end else begin
            hi_fin_d = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH]) + WIDTH'(1)
                                 : acc_q[2*WIDTH-1:WIDTH];
            lo_fin_d = neg_q ? (~acc_q[WIDTH-1:0]) + WIDTH'(1)
                             : acc_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_orig_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div_q   <= op_i[1];
                                neg_q      <= sgn_d && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                                rem_neg_q  <= sgn_d && src_a_i[WIDTH-1];
                                div_zero_q <= (src_b_i == '0);
                                a_orig_q   <= src_a_i;
                                if (op_i[1]) begin
                                    acc_q  <= {{WIDTH{1'b0}}, mag_a_d};
                                    opnd_q <= mag_b_d;
                                end else begin
                                    acc_q  <= {{WIDTH{1'b0}}, mag_b_d};
                                    opnd_q <= mag_a_d;
                                end
                                cnt_q   <= CW'(WIDTH);
                                busy_q  <= 1'b1;
                                state_q <= S_CALC;
                            end
                            OP_MTHI: hi_q <= src_a_i;
                            OP_MTLO: lo_q <= src_a_i;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    acc_q <= acc_step_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    hi_q    <= hi_fin_d;
                    lo_q    <= lo_fin_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed self-checking bench for muldiv_unit at WIDTH=32 and
//            WIDTH=8, with a small reference model for an 8-bit sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;

    logic        st32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;

    logic        st8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clock_i(clk), .reset_i(rst), .start_i(st32), .op_i(op32),
        .src_a_i(a32), .src_b_i(b32), .busy_o(busy32), .done_o(done32),
        .hi_o(hi32), .lo_o(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clock_i(clk), .reset_i(rst), .start_i(st8), .op_i(op8),
        .src_a_i(a8), .src_b_i(b8), .busy_o(busy8), .done_o(done8),
        .hi_o(hi8), .lo_o(lo8)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_hi(input bit u8);
        return u8 ? {56'd0, hi8} : {32'd0, hi32};
    endfunction
    function automatic logic [63:0] get_lo(input bit u8);
        return u8 ? {56'd0, lo8} : {32'd0, lo32};
    endfunction
    function automatic logic get_busy(input bit u8);
        return u8 ? busy8 : busy32;
    endfunction
    function automatic logic get_done(input bit u8);
        return u8 ? done8 : done32;
    endfunction

    task automatic drive(input bit u8, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (u8) begin
            st8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            st32 = st; op32 = op; a32 = a; b32 = b;
        end
    endtask

    // Issue one mul/div at a negedge (cycle 0) and follow it to cycle W+2.
    // inj > 0 raises an MTLO strobe during cycle inj, which must be ignored.
    task automatic run_op(input bit u8, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string tag, input int inj);
        int w;
        int busy_cnt;
        bit early_done;
        w = u8 ? 8 : 32;
        busy_cnt = 0;
        early_done = 1'b0;
        @(negedge clk);
        drive(u8, 1'b1, op, a, b);
        for (int c = 1; c <= w + 1; c++) begin
            @(negedge clk);
            if (c == 1)
                drive(u8, 1'b0, op, $urandom, $urandom);
            if (inj > 0 && c == inj)
                drive(u8, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'h0);
            else if (inj > 0 && c == inj + 1)
                drive(u8, 1'b0, 3'd0, 32'h0, 32'h0);
            if (get_busy(u8)) busy_cnt++;
            if (get_done(u8)) early_done = 1'b1;
        end
        @(negedge clk);
        check_val({tag, "_done"}, {63'd0, get_done(u8)}, 64'd1);
        check_val({tag, "_busy_end"}, {63'd0, get_busy(u8)}, 64'd0);
        check_val({tag, "_hi"}, get_hi(u8), u8 ? {56'd0, exp_hi[7:0]} : {32'd0, exp_hi});
        check_val({tag, "_lo"}, get_lo(u8), u8 ? {56'd0, exp_lo[7:0]} : {32'd0, exp_lo});
        check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(w + 1));
        check_val({tag, "_early_done"}, {63'd0, early_done}, 64'd0);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, {63'd0, get_done(u8)}, 64'd0);
    endtask

    // Reference model for 8-bit operations using integer arithmetic.
    task automatic model8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] hi, output logic [7:0] lo);
        int sa, sb, ua, ub, p, q, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'({24'd0, a});
        ub = int'({24'd0, b});
        hi = 8'h00;
        lo = 8'h00;
        case (op)
            3'd0: begin p = sa * sb; hi = p[15:8]; lo = p[7:0]; end
            3'd1: begin p = ua * ub; hi = p[15:8]; lo = p[7:0]; end
            3'd2: begin
                if (b == 8'h00) begin lo = 8'hFF; hi = a; end
                else begin q = sa / sb; r = sa % sb; lo = q[7:0]; hi = r[7:0]; end
            end
            default: begin
                if (b == 8'h00) begin lo = 8'hFF; hi = a; end
                else begin q = ua / ub; r = ua % ub; lo = q[7:0]; hi = r[7:0]; end
            end
        endcase
    endtask

    initial begin
        logic [7:0] eh, el, ra, rb;
        logic [2:0] rop;
        bit seen_done;

        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check_val("rst_busy32", {63'd0, busy32}, 64'd0);
        check_val("rst_done32", {63'd0, done32}, 64'd0);
        check_val("rst_hi32", {32'd0, hi32}, 64'd0);
        check_val("rst_lo32", {32'd0, lo32}, 64'd0);
        check_val("rst_busy8", {63'd0, busy8}, 64'd0);
        check_val("rst_hilo8", {48'd0, hi8, lo8}, 64'd0);
        rst = 1'b0;

        // MTHI / MTLO / reserved op
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd4, 32'h1234_5678, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        check_val("mthi_hi", {32'd0, hi32}, 64'h1234_5678);
        check_val("mthi_busy", {63'd0, busy32}, 64'd0);
        check_val("mthi_done", {63'd0, done32}, 64'd0);
        drive(1'b0, 1'b1, 3'd5, 32'hCAFE_F00D, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        check_val("mtlo_lo", {32'd0, lo32}, 64'hCAFE_F00D);
        check_val("mtlo_hi_kept", {32'd0, hi32}, 64'h1234_5678);
        drive(1'b0, 1'b1, 3'd7, 32'h5555_AAAA, 32'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        check_val("rsvd_hi", {32'd0, hi32}, 64'h1234_5678);
        check_val("rsvd_lo", {32'd0, lo32}, 64'hCAFE_F00D);
        check_val("rsvd_busy", {63'd0, busy32}, 64'd0);

        // WIDTH=32 directed arithmetic
        run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "mult", 0);
        run_op(1'b0, 3'd1, 32'hFFFF_FFFF, 32'd5, 32'h0000_0004, 32'hFFFF_FFFB, "multu", 0);
        run_op(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0);
        run_op(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf", 0);
        run_op(1'b0, 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_zero", 0);
        run_op(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero", 0);
        run_op(1'b0, 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu_inj", 5);
        run_op(1'b0, 3'd0, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0, "mult_big", 0);

        // WIDTH=8 directed and swept
        run_op(1'b1, 3'd0, 32'h80, 32'h80, 32'h40, 32'h00, "mult8", 0);
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = (i % 6 == 5) ? 8'h00 : 8'($urandom);
            model8(rop, ra, rb, eh, el);
            run_op(1'b1, rop, {24'd0, ra}, {24'd0, rb}, {24'd0, eh}, {24'd0, el},
                   $sformatf("sweep%0d_op%0d", i, rop), 0);
        end

        // Reset in the middle of a MULT
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd0, 32'h0000_0003, 32'h0000_0007);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
            if (c == 10) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_busy", {63'd0, busy32}, 64'd0);
        check_val("midrst_hi", {32'd0, hi32}, 64'd0);
        check_val("midrst_lo", {32'd0, lo32}, 64'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done32 || busy32) seen_done = 1'b1;
        end
        check_val("midrst_no_done", {63'd0, seen_done}, 64'd0);
        check_val("midrst_lo_kept", {32'd0, lo32}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
